i2s_rx: RTL and testbench
=========================

I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: DATA_W, 24, captured sample width per channel (MSB-first, two's complement, passed unmodified).
REQ-002 Port: sys_clk  input  1  system clock, 50 MHz.
REQ-003 Port: sys_rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: i2s_bclk  input  1  codec bit clock, asynchronous to sys_clk, frequency <= sys_clk/8.
REQ-005 Port: i2s_ws  input  1  codec word select; 0 = left, 1 = right.
REQ-006 Port: i2s_sdata  input  1  codec serial data, valid on i2s_bclk rising edge.
REQ-007 Port: au_data  output  DATA_W  last complete left-channel sample.
REQ-008 Port: au_vld  output  1  one-sys_clk pulse; au_data updated this cycle.
REQ-009 Port: ws_out  output  1  synchronized i2s_ws, for downstream frame-rate logic.
REQ-010 Port: frame_err  output  1  one-sys_clk pulse; word aborted by early ws change.

Function
REQ-011 i2s_bclk, i2s_ws, i2s_sdata SHALL each pass a 2-flop synchronizer; a third bclk flop SHALL form rise_det = bclk_s2 & ~bclk_s3.
REQ-012 All state updates other than output pulse clearing SHALL occur only in cycles with rise_det = 1.
REQ-013 ws_prev SHALL hold synchronized ws sampled at the previous rise_det; ws_out SHALL equal ws_prev.
REQ-014 FSM states: IDLE, SHIFT, HOLD; reset state IDLE.
REQ-015 IDLE: on rise_det with ws_s2 != ws_prev -> SHIFT, bit_cnt = 0, chan = ws_s2; data bit at this edge discarded (I2S one-bit delay).
REQ-016 SHIFT: each rise_det shifts sdata_s2 into shift register LSB, bit_cnt increments.
REQ-017 SHIFT: on rise_det with bit_cnt = DATA_W-1, shift final bit and -> HOLD; if chan = 0, au_data SHALL load the completed word and au_vld SHALL pulse in the next sys_clk cycle.
REQ-018 HOLD: extra slot bits (slot > DATA_W) ignored; on rise_det with ws change -> SHIFT per REQ-015.
REQ-019 SHIFT with ws change before bit_cnt = DATA_W-1: partial word discarded, au_data unchanged, frame_err pulses one cycle, restart SHIFT per REQ-015 with new chan.
REQ-020 au_vld and frame_err SHALL be high for exactly one sys_clk cycle per event; au_data SHALL hold between updates.
REQ-021 Right-channel words (chan = 1) SHALL be captured identically but discarded unless I2S_RIGHT_CH_EN defined.
REQ-022 bclk stopped: FSM and outputs SHALL hold indefinitely, no pulses.

Reset
REQ-023 sys_rst low SHALL asynchronously clear: synchronizers, ws_prev, shift register, bit_cnt, chan to 0; FSM to IDLE; au_data, au_vld, frame_err, ws_out to 0.
REQ-024 Reset released mid-frame: block SHALL wait in IDLE for the next ws edge; first output is the first full word after it.

Configuration
REQ-025 Macro I2S_RIGHT_CH_EN defined: additional ports au_data_r (output, DATA_W) and au_vld_r (output, 1), same rules as REQ-017/020 for chan = 1, reset 0.
REQ-026 I2S_RIGHT_CH_EN undefined: au_data_r/au_vld_r ports absent, right words discarded, left behaviour unchanged.

Verification
REQ-027 sys_clk 50 MHz, bclk 3.072 MHz, 32-bit slots, left = 24'h800001, right = 24'h7FFFFF -> au_data = 24'h800001, one au_vld per frame, frame_err never.
REQ-028 Reset asserted mid-left-word, released mid-word -> no au_vld for that word; next left word 24'h123456 captured exactly.
REQ-029 24-bit slots (ws toggles every 24 bclk), left = 24'hA5A5A5 -> au_data = 24'hA5A5A5 each frame, no frame_err.
REQ-030 ws toggles after 10 bits of a left word -> frame_err one pulse, au_data unchanged, following full words captured correctly.
REQ-031 With I2S_RIGHT_CH_EN: right = 24'h00FF00 -> au_data_r = 24'h00FF00, au_vld_r one pulse per frame; without macro, same stimulus compiles and left path matches REQ-027.
REQ-032 bclk held low 1000 sys_clk cycles -> outputs static, no pulses; on resume, capture resynchronizes at next ws edge.

Source files
------------

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes bclk/ws/sdata into sys_clk and captures DATA_W-bit words.
// Define I2S_RIGHT_CH_EN to expose the right-channel outputs au_data_r/au_vld_r.
`timescale 1ns/1ps

module i2s_rx #(
   parameter int unsigned DATA_W = 24
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              i2s_bclk,
   input  logic              i2s_ws,
   input  logic              i2s_sdata,
   output logic [DATA_W-1:0] au_data,
   output logic              au_vld,
   output logic              ws_out,
   output logic              frame_err
`ifdef I2S_RIGHT_CH_EN
   ,
   output logic [DATA_W-1:0] au_data_r,
   output logic              au_vld_r
`endif
);

   localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StHold
   } state_e;

   logic              bclk_s1_q, bclk_s2_q, bclk_s3_q;
   logic              ws_s1_q, ws_s2_q;
   logic              sdata_s1_q, sdata_s2_q;
   logic              ws_prev_q;
   logic              primed_q;
   state_e            state_q;
   logic [CntW-1:0]   bit_cnt_q;
   logic              chan_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] au_data_q;
   logic              au_vld_q;
   logic              frame_err_q;
`ifdef I2S_RIGHT_CH_EN
   logic [DATA_W-1:0] au_data_r_q;
   logic              au_vld_r_q;
`endif

   logic              rise_det;
   logic              ws_edge;
   logic [DATA_W-1:0] word_next;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         bclk_s1_q  <= 1'b0;
         bclk_s2_q  <= 1'b0;
         bclk_s3_q  <= 1'b0;
         ws_s1_q    <= 1'b0;
         ws_s2_q    <= 1'b0;
         sdata_s1_q <= 1'b0;
         sdata_s2_q <= 1'b0;
      end else begin
         bclk_s1_q  <= i2s_bclk;
         bclk_s2_q  <= bclk_s1_q;
         bclk_s3_q  <= bclk_s2_q;
         ws_s1_q    <= i2s_ws;
         ws_s2_q    <= ws_s1_q;
         sdata_s1_q <= i2s_sdata;
         sdata_s2_q <= sdata_s1_q;
      end
   end

   always_comb begin
      rise_det  = bclk_s2_q & ~bclk_s3_q;
      ws_edge   = ws_s2_q != ws_prev_q;
      word_next = {shift_q[DATA_W-2:0], sdata_s2_q};
   end

   // The first bclk rise after reset only samples ws, so a reset released during a right
   // slot is not mistaken for a ws edge.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         ws_prev_q   <= 1'b0;
         primed_q    <= 1'b0;
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         chan_q      <= 1'b0;
         shift_q     <= '0;
         au_data_q   <= '0;
         au_vld_q    <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef I2S_RIGHT_CH_EN
         au_data_r_q <= '0;
         au_vld_r_q  <= 1'b0;
`endif
      end else begin
         au_vld_q    <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef I2S_RIGHT_CH_EN
         au_vld_r_q  <= 1'b0;
`endif
         if (rise_det) begin
            ws_prev_q <= ws_s2_q;
            primed_q  <= 1'b1;
            if (primed_q) begin
               unique case (state_q)
                  StIdle, StHold: begin
                     if (ws_edge) begin
                        state_q   <= StShift;
                        bit_cnt_q <= '0;
                        chan_q    <= ws_s2_q;
                     end
                  end
                  StShift: begin
                     if (bit_cnt_q == LastBit) begin
                        shift_q <= word_next;
                        if (!chan_q) begin
                           au_data_q <= word_next;
                           au_vld_q  <= 1'b1;
                        end
`ifdef I2S_RIGHT_CH_EN
                        else begin
                           au_data_r_q <= word_next;
                           au_vld_r_q  <= 1'b1;
                        end
`endif
                        // With DATA_W-bit slots the last bit arrives on the next slot's
                        // first edge, so the next word starts here rather than in HOLD.
                        if (ws_edge) begin
                           state_q   <= StShift;
                           bit_cnt_q <= '0;
                           chan_q    <= ws_s2_q;
                        end else begin
                           state_q <= StHold;
                        end
                     end else if (ws_edge) begin
                        frame_err_q <= 1'b1;
                        state_q     <= StShift;
                        bit_cnt_q   <= '0;
                        chan_q      <= ws_s2_q;
                     end else begin
                        shift_q   <= word_next;
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                     end
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

   assign au_data   = au_data_q;
   assign au_vld    = au_vld_q;
   assign frame_err = frame_err_q;
   assign ws_out    = ws_prev_q;
`ifdef I2S_RIGHT_CH_EN
   assign au_data_r = au_data_r_q;
   assign au_vld_r  = au_vld_r_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx: slot-level model predicts captured words and frame errors.
// Builds with or without I2S_RIGHT_CH_EN.
`timescale 1ns/1ps

module tb_i2s_rx;

   localparam int unsigned DataW   = 24;
   localparam int unsigned MaxBits = 4096;

   logic             sys_clk   = 1'b0;
   logic             sys_rst   = 1'b0;
   logic             i2s_bclk  = 1'b0;
   logic             i2s_ws    = 1'b1;
   logic             i2s_sdata = 1'b0;
   logic [DataW-1:0] au_data;
   logic             au_vld;
   logic             ws_out;
   logic             frame_err;
`ifdef I2S_RIGHT_CH_EN
   logic [DataW-1:0] au_data_r;
   logic             au_vld_r;
`endif

   i2s_rx #(.DATA_W(DataW)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .i2s_bclk  (i2s_bclk),
      .i2s_ws    (i2s_ws),
      .i2s_sdata (i2s_sdata),
      .au_data   (au_data),
      .au_vld    (au_vld),
      .ws_out    (ws_out),
      .frame_err (frame_err)
`ifdef I2S_RIGHT_CH_EN
      ,
      .au_data_r (au_data_r),
      .au_vld_r  (au_vld_r)
`endif
   );

   always #10 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Bit-level stream, one entry per bclk period, plus the slot-level expectations.
   logic             ws_arr [MaxBits];
   logic             sd_arr [MaxBits];
   int               wr_ptr = 0;
   int               rd_ptr = 0;
   logic [DataW-1:0] exp_l[$];
   logic [DataW-1:0] exp_r[$];
   int               exp_err = 0;
   int               obs_err = 0;
   int               obs_vld = 0;

   // A slot of len bits on channel ch carries smp MSB-first starting one bit after its
   // ws edge; it yields a word if len >= DataW, otherwise a frame error.
   function automatic void add_slot(input logic ch, input int len, input logic [DataW-1:0] smp,
                                    input bit killed);
      int nb;
      nb = (len < int'(DataW)) ? len : int'(DataW);
      for (int k = 0; k < len; k++) ws_arr[wr_ptr + k] = ch;
      for (int k = 1; k <= len; k++) sd_arr[wr_ptr + k] = 1'($urandom);
      for (int k = 1; k <= nb; k++) sd_arr[wr_ptr + k] = smp[int'(DataW) - k];
      if (!killed) begin
         if (len >= int'(DataW)) begin
            if (!ch) exp_l.push_back(smp);
            else exp_r.push_back(smp);
         end else begin
            exp_err++;
         end
      end
      wr_ptr += len;
   endfunction

   task automatic stall_check();
      logic [DataW-1:0] d0;
      int v0, e0;
      d0 = au_data;
      v0 = obs_vld;
      e0 = obs_err;
      #(1000 * 20);
      check("stall_au_data", au_data, d0);
      check("stall_vld_cnt", obs_vld, v0);
      check("stall_err_cnt", obs_err, e0);
   endtask

   // Drives ws/sdata at bclk fall; all drive times stay 3 ns off the sys_clk grid.
   task automatic play(input int rst_lo, input int rst_hi, input int stall_at);
      while (rd_ptr < wr_ptr) begin
         if (rd_ptr == stall_at) stall_check();
         if (rd_ptr == rst_lo) sys_rst = 1'b0;
         if (rd_ptr == rst_hi) sys_rst = 1'b1;
         i2s_ws    = ws_arr[rd_ptr];
         i2s_sdata = sd_arr[rd_ptr];
         #(20 * $urandom_range(4, 9));
         if (rst_lo >= 0 && rd_ptr == rst_lo + 1) begin
            check("midrst_au_data", au_data, 0);
            check("midrst_au_vld", au_vld, 0);
            check("midrst_frame_err", frame_err, 0);
            check("midrst_ws_out", ws_out, 0);
         end
         i2s_bclk = 1'b1;
         #(20 * $urandom_range(4, 9));
         i2s_bclk = 1'b0;
         rd_ptr++;
      end
   endtask

   task automatic end_phase(input string name);
      #(20 * 20);
      check({name, "_left_pending"}, exp_l.size(), 0);
`ifdef I2S_RIGHT_CH_EN
      check({name, "_right_pending"}, exp_r.size(), 0);
`else
      exp_r.delete();
`endif
      check({name, "_err_cnt"}, obs_err, exp_err);
      check({name, "_ws_out"}, ws_out, ws_arr[wr_ptr - 1]);
   endtask

   // Output monitor: every pulse must match the model and last exactly one cycle.
   logic [DataW-1:0] last_l = '0;
   logic             vld_d  = 1'b0;
   logic             err_d  = 1'b0;
   initial forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
         last_l = '0;
         vld_d  = 1'b0;
         err_d  = 1'b0;
      end else begin
         if (au_vld) begin
            check("vld_width", vld_d, 0);
            obs_vld++;
            if (exp_l.size() == 0) check("vld_unexpected", au_vld, 0);
            else check("au_data", au_data, exp_l.pop_front());
            last_l = au_data;
         end else if (au_data !== last_l) begin
            check("au_data_hold", au_data, last_l);
            last_l = au_data;
         end
         if (frame_err) begin
            check("err_width", err_d, 0);
            obs_err++;
         end
         vld_d = au_vld;
         err_d = frame_err;
      end
   end

`ifdef I2S_RIGHT_CH_EN
   logic [DataW-1:0] last_r = '0;
   logic             vld_r_d = 1'b0;
   initial forever begin
      @(negedge sys_clk);
      if (!sys_rst) begin
         last_r  = '0;
         vld_r_d = 1'b0;
      end else begin
         if (au_vld_r) begin
            check("vld_r_width", vld_r_d, 0);
            if (exp_r.size() == 0) check("vld_r_unexpected", au_vld_r, 0);
            else check("au_data_r", au_data_r, exp_r.pop_front());
            last_r = au_data_r;
         end else if (au_data_r !== last_r) begin
            check("au_data_r_hold", au_data_r, last_r);
            last_r = au_data_r;
         end
         vld_r_d = au_vld_r;
      end
   end
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0, e0, s;
      #203;
      check("rst_au_data", au_data, 0);
      check("rst_au_vld", au_vld, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_ws_out", ws_out, 0);
      sys_rst = 1'b1;
      #(20 * 5);

      // 32-bit slots, fixed extreme samples.
      v0 = obs_vld;
      add_slot(1'b1, 8, '0, 1'b1);
      for (int f = 0; f < 4; f++) begin
         add_slot(1'b0, 32, 24'h800001, 1'b0);
         add_slot(1'b1, 32, 24'h7FFFFF, 1'b0);
      end
      play(-1, -1, -1);
      end_phase("slot32");
      check("slot32_vld_cnt", obs_vld - v0, 4);
      check("slot32_au_data", au_data, 24'h800001);

      // 24-bit slots: the LSB lands on the first edge of the following slot.
      v0 = obs_vld;
      for (int f = 0; f < 4; f++) begin
         add_slot(1'b0, 24, 24'hA5A5A5, 1'b0);
         add_slot(1'b1, (f == 3) ? 32 : 24, (f == 0) ? 24'h00FF00 : 24'($urandom), 1'b0);
      end
      play(-1, -1, -1);
      end_phase("slot24");
      check("slot24_vld_cnt", obs_vld - v0, 4);

      // Left word aborted after 10 bits.
      e0 = obs_err;
      add_slot(1'b0, 10, 24'($urandom), 1'b0);
      add_slot(1'b1, 32, 24'($urandom), 1'b0);
      add_slot(1'b0, 32, 24'($urandom), 1'b0);
      add_slot(1'b1, 32, 24'($urandom), 1'b0);
      play(-1, -1, -1);
      end_phase("abort");
      check("abort_err_pulses", obs_err - e0, 1);

      // Reset asserted and released inside a left word.
      s = wr_ptr;
      add_slot(1'b0, 32, 24'($urandom), 1'b1);
      add_slot(1'b1, 32, 24'($urandom), 1'b0);
      add_slot(1'b0, 32, 24'h123456, 1'b0);
      add_slot(1'b1, 32, 24'($urandom), 1'b0);
      play(s + 6, s + 12, -1);
      end_phase("midrst");
      check("midrst_au_data_final", au_data, 24'h123456);

      // bclk stopped mid-word for 1000 sys_clk cycles.
      s = wr_ptr;
      add_slot(1'b0, 32, 24'($urandom), 1'b0);
      add_slot(1'b1, 32, 24'($urandom), 1'b0);
      play(-1, -1, s + 15);
      end_phase("stall");

      // Random slot lengths, including short and padded slots.
      for (int f = 0; f < 12; f++) begin
         for (int c = 0; c < 2; c++) begin
            int len;
            len = ($urandom_range(0, 9) < 3) ? $urandom_range(2, 23) : $urandom_range(24, 40);
            if (f == 11 && c == 1) len = 32;
            add_slot(1'(c), len, 24'($urandom), 1'b0);
         end
      end
      play(-1, -1, -1);
      end_phase("random");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
